// File: rtl/led_7seg_reader.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the hex value of each digit.
// Stable digit samples are collected into frames, and each changed frame is offered on a valid/ready handshake.
`timescale 1ns/1ps
module led_7seg_reader #(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              LED,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] val,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    err,
    output logic                    valid,
    input  logic                    ready
);

    localparam int         FW      = 5*NUM_DIGITS + 1;
    localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES - 1);

    typedef enum logic {COLLECT, OFFER} state_t;

    // Result layout is {illegal, blank, nibble}.
    function automatic logic [5:0] decode_seg(input logic [6:0] led);
        logic [6:0] lit;
        logic [5:0] res;
        lit = ~led;
        res = 6'b000000;
        if (led == 7'h7F) begin
            res[4] = 1'b1;
        end else begin
            case (lit)
                7'b0111111: res[3:0] = 4'h0;
                7'b0000110: res[3:0] = 4'h1;
                7'b1011011: res[3:0] = 4'h2;
                7'b1001111: res[3:0] = 4'h3;
                7'b1100110: res[3:0] = 4'h4;
                7'b1101101: res[3:0] = 4'h5;
                7'b1111101: res[3:0] = 4'h6;
                7'b0000111: res[3:0] = 4'h7;
                7'b1111111: res[3:0] = 4'h8;
                7'b1101111: res[3:0] = 4'h9;
                7'b1110111: res[3:0] = 4'hA;
                7'b1111100: res[3:0] = 4'hB;
                7'b0111001: res[3:0] = 4'hC;
                7'b1011110: res[3:0] = 4'hD;
                7'b1111001: res[3:0] = 4'hE;
                7'b1110001: res[3:0] = 4'hF;
                default:    res[5]   = 1'b1;
            endcase
        end
        return res;
    endfunction

    logic [6:0]              led_p0, led_p1;
    logic [NUM_DIGITS-1:0]   sel_p0, sel_p1;
    logic [7:0]              run_cnt;
    logic                    match, capture;
    logic [5:0]              dec;
    logic [NUM_DIGITS-1:0]   cap_mask;

    logic [4*NUM_DIGITS-1:0] slot_val;
    logic [NUM_DIGITS-1:0]   slot_blank, slot_ill;
    logic [NUM_DIGITS-1:0]   seen, seen_n;
    logic [FW-1:0]           work_frame, last_frame;
    logic                    frame_acc;

    state_t state, state_n;
    logic   load, accept, clear_seen;

    // Stage p0 holds the current bus sample and stage p1 holds the previous one.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_p0  <= '0;
            led_p1  <= '0;
            sel_p0  <= '0;
            sel_p1  <= '0;
            run_cnt <= '0;
        end else begin
            led_p0 <= LED;
            sel_p0 <= dig_sel;
            led_p1 <= led_p0;
            sel_p1 <= sel_p0;
            if (!match)
                run_cnt <= '0;
            else if (run_cnt != RUN_MAX)
                run_cnt <= run_cnt + 8'd1;
        end
    end

    // run_cnt counts adjacent matching samples, so STABLE_CYCLES identical samples give STABLE_CYCLES-1 matches.
    assign match    = $onehot(sel_p0) && (led_p0 == led_p1) && (sel_p0 == sel_p1);
    assign capture  = match && (run_cnt == RUN_MAX - 8'd1);
    assign dec      = decode_seg(led_p0);
    assign cap_mask = capture ? sel_p0 : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_mask[i]) begin
                slot_val[4*i +: 4] <= dec[3:0];
                slot_blank[i]      <= dec[4];
                slot_ill[i]        <= dec[5];
            end
        end
    end

    assign work_frame = {slot_val, slot_blank, |slot_ill};

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        accept     = 1'b0;
        clear_seen = 1'b0;
        case (state)
            COLLECT: begin
                if (&seen) begin
                    clear_seen = 1'b1;
                    if (!frame_acc || (work_frame != last_frame)) begin
                        load    = 1'b1;
                        state_n = OFFER;
                    end
                end
            end
            OFFER: begin
                if (valid && ready) begin
                    accept  = 1'b1;
                    state_n = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
        // A capture landing on the same edge as a frame completion is kept.
        seen_n = clear_seen ? cap_mask : (seen | cap_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            seen      <= '0;
            val       <= '0;
            blank     <= '0;
            err       <= 1'b0;
            valid     <= 1'b0;
            frame_acc <= 1'b0;
        end else begin
            state <= state_n;
            seen  <= seen_n;
            if (load) begin
                val   <= slot_val;
                blank <= slot_blank;
                err   <= |slot_ill;
                valid <= 1'b1;
            end
            if (accept) begin
                valid     <= 1'b0;
                frame_acc <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            last_frame <= {val, blank, err};
    end

endmodule

// File: tb/tb_led_7seg_reader.sv
// Self-checking bench for led_7seg_reader: directed scenarios plus randomized scans.
// The randomized scans are checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_led_7seg_reader;

    localparam int ND = 2;
    localparam int SC = 4;
    localparam int FW = 5*ND + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic [6:0]    LED;
    logic [ND-1:0] dig_sel;
    logic [4*ND-1:0] val;
    logic [ND-1:0] blank;
    logic          err;
    logic          valid;

    int errors = 0;
    int checks = 0;

    logic [FW-1:0] obs_q[$];
    logic [FW-1:0] exp_q[$];
    logic [6:0]    seg_tab[16];

    // Reference model state, kept at the level of sample runs and frames.
    logic [6:0]    m_prev_led;
    logic [ND-1:0] m_prev_sel;
    bit            m_prev_ok;
    int            m_run;
    logic [3:0]    m_nib[ND];
    bit            m_blank[ND];
    bit            m_ill[ND];
    logic [ND-1:0] m_seen;
    logic [FW-1:0] m_last;
    bit            m_have;

    led_7seg_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .LED(LED), .dig_sel(dig_sel),
        .val(val), .blank(blank), .err(err), .valid(valid), .ready(ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!reset && valid && ready)
            obs_q.push_back({val, blank, err});

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] hexled(input logic [3:0] h);
        return ~seg_tab[h];
    endfunction

    function automatic logic [5:0] mdec(input logic [6:0] led);
        if (led == 7'h7F) return 6'b010000;
        for (int h = 0; h < 16; h++)
            if (~led == seg_tab[h]) return {2'b00, 4'(h)};
        return 6'b100000;
    endfunction

    task automatic model_reset();
        m_prev_led = '0;
        m_prev_sel = '0;
        m_prev_ok  = 0;
        m_run      = 0;
        m_seen     = '0;
        m_have     = 0;
        m_last     = '0;
        for (int d = 0; d < ND; d++) begin
            m_nib[d] = 4'h0; m_blank[d] = 0; m_ill[d] = 0;
        end
    endtask

    task automatic model_step(input logic [6:0] led, input logic [ND-1:0] sel);
        bit            oh;
        logic [5:0]    dd;
        logic [4*ND-1:0] fv;
        logic [ND-1:0] fb;
        logic          fe;
        logic [FW-1:0] fr;
        oh = ($countones(sel) == 1);
        if (oh && m_prev_ok && led == m_prev_led && sel == m_prev_sel) m_run++;
        else m_run = oh ? 1 : 0;
        m_prev_led = led;
        m_prev_sel = sel;
        m_prev_ok  = oh;
        if (m_run == SC) begin
            dd = mdec(led);
            for (int d = 0; d < ND; d++)
                if (sel[d]) begin
                    m_nib[d] = dd[3:0]; m_blank[d] = dd[4]; m_ill[d] = dd[5]; m_seen[d] = 1'b1;
                end
            if (&m_seen) begin
                fe = 1'b0;
                for (int d = 0; d < ND; d++) begin
                    fv[4*d +: 4] = m_nib[d];
                    fb[d] = m_blank[d];
                    fe = fe | m_ill[d];
                end
                fr = {fv, fb, fe};
                if (!m_have || fr != m_last) begin
                    exp_q.push_back(fr);
                    m_last = fr;
                    m_have = 1;
                end
                m_seen = '0;
            end
        end
    endtask

    task automatic drive(input logic [6:0] led, input logic [ND-1:0] sel);
        @(posedge clk); #2;
        LED = led;
        dig_sel = sel;
        model_step(led, sel);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(7'h7F, '0);
    endtask

    task automatic scan(input logic [6:0] l0, input logic [6:0] l1, input int hold);
        repeat (hold) drive(l0, 2'b01);
        repeat (hold) drive(l1, 2'b10);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        reset = 1'b1; LED = 7'h7F; dig_sel = '0;
        repeat (n) @(posedge clk);
        #2 reset = 1'b0;
        model_reset();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset(3);
        checks++; if (val !== '0)   begin errors++; $display("FAIL reset_val: got %h expected 00", val); end
        checks++; if (blank !== '0) begin errors++; $display("FAIL reset_blank: got %b expected 00", blank); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    endtask

    task automatic test_basic();
        logic [FW-1:0] got;
        ready = 1'b1;
        scan(hexled(4'h2), hexled(4'hE), 6);
        idle(6);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d frames expected 1", obs_q.size()); end
        got = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
        checks++; if (got !== {8'hE2, 2'b00, 1'b0}) begin errors++; $display("FAIL basic_frame: got %h expected %h", got, {8'hE2, 2'b00, 1'b0}); end
        obs_q.delete();
    endtask

    task automatic test_repeat();
        logic [FW-1:0] got;
        repeat (3) scan(hexled(4'h2), hexled(4'hE), 6);
        idle(6);
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL repeat_no_offer: got %0d frames expected 0", obs_q.size()); end
        obs_q.delete();
        scan(hexled(4'h1), hexled(4'hE), 6);
        idle(6);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL repeat_change_count: got %0d frames expected 1", obs_q.size()); end
        got = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
        checks++; if (got !== {8'hE1, 2'b00, 1'b0}) begin errors++; $display("FAIL repeat_change_frame: got %h expected %h", got, {8'hE1, 2'b00, 1'b0}); end
        obs_q.delete();
    endtask

    task automatic test_no_capture();
        logic [FW-1:0] got;
        do_reset(2);
        ready = 1'b1;
        repeat (4) scan(hexled(4'h3), hexled(4'h4), SC - 1);
        idle(6);
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL short_hold: got %0d frames expected 0", obs_q.size()); end
        repeat (2) begin
            repeat (3) drive(hexled(4'h5), 2'b01);
            drive(hexled(4'h6), 2'b01);
            repeat (2) drive(hexled(4'h5), 2'b01);
            repeat (6) drive(hexled(4'hA), 2'b10);
        end
        idle(6);
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL glitch_hold: got %0d frames expected 0", obs_q.size()); end
        repeat (10) drive(hexled(4'h5), 2'b11);
        idle(6);
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL multi_sel: got %0d frames expected 0", obs_q.size()); end
        repeat (SC) drive(hexled(4'h5), 2'b01);
        idle(6);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL exact_hold_count: got %0d frames expected 1", obs_q.size()); end
        got = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
        checks++; if (got !== {8'hA5, 2'b00, 1'b0}) begin errors++; $display("FAIL exact_hold_frame: got %h expected %h", got, {8'hA5, 2'b00, 1'b0}); end
        obs_q.delete();
    endtask

    task automatic test_blank_illegal();
        logic [FW-1:0] got;
        do_reset(2);
        ready = 1'b1;
        scan(7'h55, 7'h7F, 6);
        idle(6);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL blank_ill_count: got %0d frames expected 1", obs_q.size()); end
        got = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
        checks++; if (got !== {8'h00, 2'b10, 1'b1}) begin errors++; $display("FAIL blank_ill_frame: got %h expected %h", got, {8'h00, 2'b10, 1'b1}); end
        obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] got;
        do_reset(2);
        ready = 1'b1;
        scan(hexled(4'h2), hexled(4'hE), 6);
        idle(6);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL bp_first_count: got %0d frames expected 1", obs_q.size()); end
        obs_q.delete();
        ready = 1'b0;
        scan(hexled(4'h7), hexled(4'h3), 8);
        repeat (2) begin
            for (int c = 0; c < 10; c++) begin
                drive(c < 5 ? hexled(4'hC) : hexled(4'hD), c < 5 ? 2'b01 : 2'b10);
                checks++;
                if ({valid, val} !== {1'b1, 8'h37}) begin
                    errors++; $display("FAIL bp_hold: got valid=%b val=%h expected valid=1 val=37", valid, val);
                end
            end
        end
        ready = 1'b1;
        drive(hexled(4'hC), 2'b01);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got valid=%b expected 0", valid); end
        repeat (4) drive(hexled(4'hC), 2'b01);
        repeat (5) drive(hexled(4'hD), 2'b10);
        idle(6);
        checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL bp_count: got %0d frames expected 2", obs_q.size()); end
        got = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
        checks++; if (got !== {8'h37, 2'b00, 1'b0}) begin errors++; $display("FAIL bp_held_frame: got %h expected %h", got, {8'h37, 2'b00, 1'b0}); end
        got = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
        checks++; if (got !== {8'hDC, 2'b00, 1'b0}) begin errors++; $display("FAIL bp_next_frame: got %h expected %h", got, {8'hDC, 2'b00, 1'b0}); end
        obs_q.delete();
    endtask

    task automatic test_reset_offer();
        logic [FW-1:0] got;
        do_reset(2);
        ready = 1'b0;
        scan(hexled(4'h2), hexled(4'hE), 8);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ro_pending: got valid=%b expected 1", valid); end
        reset = 1'b1; LED = 7'h7F; dig_sel = '0;
        @(posedge clk); #2;
        checks++;
        if ({valid, err, blank, val} !== '0) begin
            errors++; $display("FAIL ro_cleared: got valid=%b err=%b blank=%b val=%h expected all 0", valid, err, blank, val);
        end
        reset = 1'b0;
        model_reset();
        obs_q.delete();
        ready = 1'b1;
        scan(hexled(4'h2), hexled(4'hE), 6);
        idle(6);
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL ro_reoffer_count: got %0d frames expected 1", obs_q.size()); end
        got = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
        checks++; if (got !== {8'hE2, 2'b00, 1'b0}) begin errors++; $display("FAIL ro_reoffer_frame: got %h expected %h", got, {8'hE2, 2'b00, 1'b0}); end
        obs_q.delete();
    endtask

    task automatic test_random();
        logic [6:0]    fl[ND];
        logic [ND-1:0] fs[ND];
        int            kind, hold, n;
        bit            glitch;
        do_reset(2);
        ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            for (int d = 0; d < ND; d++) begin
                kind = $urandom_range(0, 9);
                fs[d] = ND'(1) << d;
                if (kind == 0) begin
                    fl[d] = hexled(4'($urandom_range(0, 15)));
                    fs[d] = ($urandom_range(0, 1) == 1) ? '1 : '0;
                end else if (kind == 1) fl[d] = 7'h7F;
                else if (kind == 2) fl[d] = 7'($urandom_range(0, 127));
                else fl[d] = hexled(4'($urandom_range(0, 15)));
            end
            repeat ($urandom_range(1, 3)) begin
                for (int d = 0; d < ND; d++) begin
                    hold = $urandom_range(2, 7);
                    glitch = ($urandom_range(0, 5) == 0);
                    for (int c = 0; c < hold; c++)
                        drive((glitch && c == hold/2) ? (fl[d] ^ 7'h01) : fl[d], fs[d]);
                end
            end
        end
        idle(8);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d frames expected %0d", obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_frame[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        reset = 1'b1;
        ready = 1'b1;
        LED = 7'h7F;
        dig_sel = '0;
        model_reset();
        test_reset();
        test_basic();
        test_repeat();
        test_no_capture();
        test_blank_illegal();
        test_backpressure();
        test_reset_offer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_7seg_reader.md
Name: led_7seg_reader

Overview:
- Reverse of the display decoder: watches a multiplexed, active-low 7-segment bus plus a one-hot digit strobe and recovers the hex value shown on each digit.
- Filters glitches with a stability counter, assembles one frame per full scan and offers changed frames downstream on a valid/ready handshake.
- Used for on-board self-check of the display path and as a bench monitor.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits; val width = 4*NUM_DIGITS.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured; legal range 2..255.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- LED  input  7  segment bus, active-low: bit0=a … bit6=g, 0 = segment lit.
- dig_sel  input  NUM_DIGITS  one-hot, active-high digit strobe; bit i = digit i driven.
- val  output  4*NUM_DIGITS  recovered frame; digit i in bits [4i+3:4i].
- blank  output  NUM_DIGITS  bit i = digit i showed all segments off.
- err  output  1  frame contained at least one illegal pattern.
- valid  output  1  frame offered.
- ready  input  1  consumer accepts frame.

Behaviour:
- Decode (lit-segment pattern = ~LED, bits g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. LED=7'h7F -> blank, nibble 0. Any other pattern -> illegal, nibble 0, blank 0.
- Input stage: LED and dig_sel registered each cycle (1-cycle sample). Stability counter compares sample with previous sample; mismatch or non-one-hot dig_sel (zero or >1 bits) -> counter clears, no capture.
- Capture: when the same one-hot pair has been sampled on STABLE_CYCLES consecutive edges, decoded nibble, blank and illegal flags are written into the working slot for that digit and its seen bit set. Exactly once per stable run; holding longer does not recapture. Counter saturates. Run of STABLE_CYCLES-1 samples -> no capture.
- FSM states: COLLECT, OFFER.
  - COLLECT: capture as above. When all seen bits are set, compare working frame {val, blank, err} with the last accepted frame. If different, or no frame accepted since reset: load output registers, valid=1, clear seen, go OFFER (valid high on the edge after the completing capture). Otherwise clear seen, stay COLLECT.
  - OFFER: val/blank/err/valid held stable until handshake. Capture into working slots continues. On valid&&ready at an edge: store frame as last accepted, valid=0, go COLLECT with seen bits retained. Slot completing on the same edge as the handshake is kept, not lost.
- err = OR of illegal flags across the frame's digits.
- A digit recaptured before the frame completes overwrites its slot (latest wins).
- Reset (any cycle, including mid-OFFER): val=0, blank=0, err=0, valid=0, state COLLECT, counter=0, seen=0, sample regs=0, "no frame accepted" flag set. Pending offer is discarded.
- ready ignored while valid=0.

Test Plan:
- NUM_DIGITS=2, STABLE_CYCLES=4, ready=1: digit0 LED=~7'b1011011 (2), digit1 LED=~7'b1111001 (E), each held 6 cycles -> one valid pulse, val=8'hE2, blank=0, err=0.
- Same frame scanned repeatedly -> no further valid; change digit0 to ~7'b0000110 -> val=8'hE1 offered once.
- Digit held 3 cycles (STABLE_CYCLES-1), or 1-cycle glitch mid-hold, or dig_sel=2'b11 -> no capture; valid stays 0.
- Digit1 LED=7'h7F, digit0 LED=7'h55 -> val=8'h00, blank=2'b10, err=1.
- ready=0 for 20 cycles while display changes -> val/valid held constant; ready=1 at one edge -> valid drops next cycle, next changed frame follows.
- Assert reset during OFFER -> next cycle all outputs 0; identical frame afterwards is offered again (first frame after reset).
